inst_issue_queue_way1: RTL and testbench
========================================

Name: inst_issue_queue_way1

Overview:
- Instruction issue queue sitting between the fetch stage and the way1 decoder of the dual-issue core.
- Buffers fetched instruction packets (instruction word plus its PC) in a small synchronous FIFO.
- Tags each packet with a rotating 2-bit pipeline ID (pID) as it enters.
- Presents the oldest packet to the way1 decoder over a valid/ready handshake, and supports a pipeline flush.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- INST_W, 32: instruction word width.
- ADDR_W, 32: instruction address width.
- PID_W, 2: pipeline ID width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset.
- flush_i  in  1  pipeline flush (branch mispredict or trap).
- fetch_valid_i  in  1  fetch packet valid.
- fetch_inst_i  in  INST_W  fetched instruction word.
- fetch_instAddr_i  in  ADDR_W  PC of the fetched instruction.
- fetch_ready_o  out  1  queue can accept a packet this cycle.
- valid_o  out  1  head packet valid, to decoder.
- inst_o  out  INST_W  head instruction, to decoder.
- instAddr_o  out  ADDR_W  head PC, to decoder.
- way1_pID_o  out  PID_W  head pID, to decoder.
- ready_i  in  1  decoder/DU register accepts the head packet.
- count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock, reset is synchronous and active-high. On a clk edge with rst=1:
  - wr_ptr, rd_ptr, count and the pID counter clear to 0.
  - Storage contents are don't-care.
- Outputs after reset: valid_o=0, count_o=0, fetch_ready_o=1, way1_pID_o=0, inst_o=NOP (32'h00000013), instAddr_o=0.
- While rst=1: fetch_ready_o=0.
- Enqueue:
  - Occurs when fetch_valid_i && fetch_ready_o.
  - Writes {inst, addr, pid_cnt} at wr_ptr, increments wr_ptr (wraps modulo DEPTH) and increments pid_cnt (wraps 3->0).
- Dequeue:
  - Occurs when valid_o && ready_i.
  - Increments rd_ptr (wraps modulo DEPTH).
- fetch_ready_o = (count != DEPTH) && !flush_i && !rst. Combinational; independent of ready_i, so there is no enqueue-while-full even with a same-cycle dequeue.
- Head outputs:
  - valid_o = (count != 0).
  - inst_o, instAddr_o and way1_pID_o are read combinationally from the entry at rd_ptr.
  - When the queue is empty, inst_o=NOP, instAddr_o=0, way1_pID_o=0.
- Latency: a packet enqueued at edge N is visible on valid_o after edge N; there is no fetch-to-decoder bypass.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Handshake rule: once valid_o=1, the head fields stay stable until dequeued or flushed.
- Flush:
  - flush_i=1 at an edge clears rd_ptr, wr_ptr and count.
  - Any same-cycle enqueue is dropped (fetch_ready_o is already 0).
  - A same-cycle dequeue still counts as accepted by the decoder.
  - pid_cnt is NOT cleared by flush; post-flush packets continue the pID sequence, so downstream stale-ID checks remain valid.
- Precedence: rst > flush_i > enqueue/dequeue.
- count_o is a registered occupancy: 0..DEPTH.

Decomposition:
- Shared package (core_pkg):
  - NOP_INST = 32'h00000013.
  - PID_W.
  - Instruction-packet struct/concat layout {inst, addr, pid}.
- Sub-module inst_queue_ram:
  - DEPTH x (INST_W+ADDR_W+PID_W) register array.
  - Single write port; asynchronous read at rd_ptr.
  - No reset on the data array.
- Pointer, count and pID logic live in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then rst=0 with no traffic.
  - Required: valid_o=0, inst_o=32'h00000013, count_o=0, fetch_ready_o=1 after rst falls.
- Fill to full:
  - Stimulus: ready_i=0; enqueue 4 packets with inst 0x00100093..0x00400093 and PC 0x80000000..0x8000000C.
  - Required: count_o=4, fetch_ready_o=0, head inst=0x00100093, PC=0x80000000, pID=0.
  - Required: a 5th fetch_valid_i is ignored.
- Drain in order:
  - Stimulus: from the full state, ready_i=1 for 4 cycles.
  - Required: pIDs 0,1,2,3 appear in order with matching inst/PC; then valid_o=0 and count_o=0.
- Streaming:
  - Stimulus: fetch_valid_i=1 and ready_i=1 continuously for 10 packets.
  - Required: count_o holds at 1 after the first cycle; throughput 1 per cycle; pIDs wrap 0,1,2,3,0,1…
  - Required: both pointers wrap past DEPTH correctly.
- Flush mid-stream:
  - Stimulus: 3 entries queued (pIDs 0..2); assert flush_i together with fetch_valid_i.
  - Required: the next cycle has count_o=0 and valid_o=0; the flush-cycle packet is dropped.
  - Required: the next enqueued packet carries pID=3.
- Reset mid-operation:
  - Stimulus: 2 entries queued with pid_cnt=2; assert rst for 1 cycle.
  - Required: count_o=0 and valid_o=0; the next enqueued packet carries pID=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the way1 issue queue: default widths, the NOP word
// and the layout of a buffered instruction packet.
package core_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int PID_W  = 2;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Packet layout in the queue storage, MSB first: {inst, addr, pid}.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [PID_W-1:0]  pid;
    } inst_pkt_t;

endpackage

// File: rtl/inst_issue_queue_way1_if.sv
// Fetch-side and decoder-side handshake bundle of the way1 issue queue.
// The queue takes the slave view; whatever drives fetch/decode takes the master view.
interface inst_issue_queue_way1_if #(
    parameter int DEPTH  = 4,
    parameter int INST_W = core_pkg::INST_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int PID_W  = core_pkg::PID_W
);
    import core_pkg::*;

    logic                      flush_i;
    logic                      fetch_valid_i;
    logic [INST_W-1:0]         fetch_inst_i;
    logic [ADDR_W-1:0]         fetch_instAddr_i;
    logic                      fetch_ready_o;
    logic                      valid_o;
    logic [INST_W-1:0]         inst_o;
    logic [ADDR_W-1:0]         instAddr_o;
    logic [PID_W-1:0]          way1_pID_o;
    logic                      ready_i;
    logic [$clog2(DEPTH):0]    count_o;

    modport slave (
        input  flush_i, fetch_valid_i, fetch_inst_i, fetch_instAddr_i, ready_i,
        output fetch_ready_o, valid_o, inst_o, instAddr_o, way1_pID_o, count_o
    );

    modport master (
        output flush_i, fetch_valid_i, fetch_inst_i, fetch_instAddr_i, ready_i,
        input  fetch_ready_o, valid_o, inst_o, instAddr_o, way1_pID_o, count_o
    );

endinterface

// File: rtl/inst_queue_ram.sv
// Packet storage for the issue queue: one synchronous write port and an
// asynchronous read port. The array is deliberately left without reset.
module inst_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    import core_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_issue_queue_way1.sv
// Way1 instruction issue queue: buffers fetch packets, tags each with a
// rotating pipeline ID and hands the oldest one to the decoder.
module inst_issue_queue_way1 #(
    parameter int DEPTH  = 4,
    parameter int INST_W = core_pkg::INST_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int PID_W  = core_pkg::PID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    inst_issue_queue_way1_if.slave q_if
);
    import core_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = INST_W + ADDR_W + PID_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PID_W-1:0] pid_cnt_q, pid_cnt_d;
    logic             not_full;
    logic             not_empty;
    logic             fetch_ready;
    logic             enq;
    logic             deq;
    logic [PKT_W-1:0] rd_pkt;

    // Ready ignores ready_i on purpose, so a full queue never takes a packet
    // even when the head leaves in the same cycle.
    always_comb begin
        not_full    = (count_q != CNT_W'(DEPTH));
        not_empty   = (count_q != '0);
        fetch_ready = not_full && !q_if.flush_i && !rst;
        enq         = q_if.fetch_valid_i && fetch_ready;
        deq         = not_empty && q_if.ready_i;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pid_cnt_d = pid_cnt_q;

        // pid_cnt survives a flush so post-flush packets keep a fresh pID.
        if (q_if.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                pid_cnt_d = pid_cnt_q + PID_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pid_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pid_cnt_q <= pid_cnt_d;
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (enq),
        .waddr_i (wr_ptr_q),
        .wdata_i ({q_if.fetch_inst_i, q_if.fetch_instAddr_i, pid_cnt_q}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_pkt)
    );

    assign q_if.fetch_ready_o = fetch_ready;
    assign q_if.valid_o       = not_empty;
    assign q_if.count_o       = count_q;
    assign q_if.inst_o        = not_empty ? rd_pkt[PKT_W-1 -: INST_W] : INST_W'(NOP_INST);
    assign q_if.instAddr_o    = not_empty ? rd_pkt[ADDR_W+PID_W-1 -: ADDR_W] : '0;
    assign q_if.way1_pID_o    = not_empty ? rd_pkt[PID_W-1:0] : '0;

endmodule

// File: tb/tb_inst_issue_queue_way1.sv
// Self-checking bench for the way1 issue queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_inst_issue_queue_way1;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [1:0]  pid;
    } pkt_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pkt_t model_q[$];
    int   model_pid;
    bit   model_known;

    inst_issue_queue_way1_if #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32), .PID_W(2)) dut_if ();

    inst_issue_queue_way1 #(
        .DEPTH  (DEPTH),
        .INST_W (32),
        .ADDR_W (32),
        .PID_W  (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs mid-period, compare outputs to the model,
    // then advance the model as the coming clock edge will.
    task automatic applyStimulus(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic rdy, input logic fl, input logic r);
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
        logic [1:0]  exp_pid;
        pkt_t        p;
        @(negedge clk);
        rst                     = r;
        dut_if.fetch_valid_i    = fv;
        dut_if.fetch_inst_i     = inst;
        dut_if.fetch_instAddr_i = pc;
        dut_if.ready_i          = rdy;
        dut_if.flush_i          = fl;
        #1;
        exp_valid = (model_q.size() != 0);
        exp_ready = (model_q.size() != DEPTH) && !fl && !r;
        exp_inst  = exp_valid ? model_q[0].inst : NOP;
        exp_addr  = exp_valid ? model_q[0].addr : 32'h0;
        exp_pid   = exp_valid ? model_q[0].pid : 2'd0;
        if (model_known) begin
            checkOutput("valid_o",       64'(dut_if.valid_o),       64'(exp_valid));
            checkOutput("count_o",       64'(dut_if.count_o),       64'(model_q.size()));
            checkOutput("fetch_ready_o", 64'(dut_if.fetch_ready_o), 64'(exp_ready));
            checkOutput("inst_o",        64'(dut_if.inst_o),        64'(exp_inst));
            checkOutput("instAddr_o",    64'(dut_if.instAddr_o),    64'(exp_addr));
            checkOutput("way1_pID_o",    64'(dut_if.way1_pID_o),    64'(exp_pid));
        end
        if (r) begin
            model_q.delete();
            model_pid   = 0;
            model_known = 1'b1;
        end else if (model_known) begin
            if (fl) begin
                model_q.delete();
            end else begin
                if (exp_valid && rdy) void'(model_q.pop_front());
                if (fv && exp_ready) begin
                    p.inst = inst;
                    p.addr = pc;
                    p.pid  = 2'(model_pid);
                    model_q.push_back(p);
                    model_pid = (model_pid + 1) % 4;
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_pid   = 0;
        model_known = 1'b0;
        rst                     = 1'b1;
        dut_if.fetch_valid_i    = 1'b0;
        dut_if.fetch_inst_i     = '0;
        dut_if.fetch_instAddr_i = '0;
        dut_if.ready_i          = 1'b0;
        dut_if.flush_i          = 1'b0;

        // Reset then idle
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("idle_nop", 64'(dut_if.inst_o), 64'(NOP));
        checkOutput("idle_ready", 64'(dut_if.fetch_ready_o), 64'd1);

        // Fill to full, then a fifth fetch that must be ignored
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0010_0093 + 32'(i) * 32'h0010_0000,
                          32'h8000_0000 + 32'(i) * 32'd4, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h9000_0000, 1'b0, 1'b0, 1'b0);
        checkOutput("full_count", 64'(dut_if.count_o), 64'd4);
        checkOutput("full_ready", 64'(dut_if.fetch_ready_o), 64'd0);
        checkOutput("full_head_inst", 64'(dut_if.inst_o), 64'h0010_0093);
        checkOutput("full_head_pc", 64'(dut_if.instAddr_o), 64'h8000_0000);

        // Drain in order
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        checkOutput("drain_empty", 64'(dut_if.valid_o), 64'd0);

        // Streaming with wrap of both pointers and the pID
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h0000_1013 + 32'(i << 12), 32'h8000_1000 + 32'(i) * 32'd4,
                          1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b0);

        // Flush mid-stream: three queued, flush with a colliding fetch
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0050_0093 + 32'(i), 32'h8000_2000 + 32'(i) * 32'd4,
                          1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h0BAD_0093, 32'h8000_3000, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        checkOutput("flush_count", 64'(dut_if.count_o), 64'd0);
        applyStimulus(1'b1, 32'h0060_0093, 32'h8000_4000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("flush_next_pid", 64'(dut_if.way1_pID_o), 64'd3);

        // Reset mid-operation restarts the pID sequence
        idle(1'b1);
        applyStimulus(1'b1, 32'h0070_0093, 32'h8000_5000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0080_0093, 32'h8000_5004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("rst_valid", 64'(dut_if.valid_o), 64'd0);
        applyStimulus(1'b1, 32'h0090_0093, 32'h8000_6000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("rst_next_pid", 64'(dut_if.way1_pID_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 49) == 0);
        end
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
